instr_mem_loader: RTL

//  Upstream feeder of the CPU core. Receives a length-prefixed byte stream over a

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_word_assembler.sv | 58 +++++
 rtl/instr_mem_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module : loader_pkg
//  Brief  : Shared types and constants for the instruction-memory loader.
//  Rev    : 1.0  initial release
// ============================================================================
package loader_pkg;

    localparam int RX_BYTE_W = 8;   // width of one stream byte
    localparam int LEN_W     = 16;  // width of the word-count prefix

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN0    = 3'd1,
        LEN1    = 3'd2,
        COLLECT = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module : loader_word_assembler
//  Brief  : Collects bytes little-endian into one instruction word. word_out
//           shows the word as it would look if byte_in were taken now, so the
//           caller can register it on the same edge as the final byte.
//  Rev    : 1.0  initial release
// ============================================================================
module loader_word_assembler
    import loader_pkg::*;
#(
    parameter int INSTRUCTION_LENGTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          byte_valid,
    input  logic [RX_BYTE_W-1:0]          byte_in,
    output logic [INSTRUCTION_LENGTH-1:0] word_out,
    output logic                          word_complete
);

    localparam int c_BYTES = INSTRUCTION_LENGTH / RX_BYTE_W;

    generate
        if (c_BYTES == 1) begin : g_single
            assign word_out      = byte_in;
            assign word_complete = byte_valid;
        end else begin : g_multi
            localparam int c_IDX_W = $clog2(c_BYTES);

            logic [c_IDX_W-1:0]                      r_byte_idx;
            logic [INSTRUCTION_LENGTH-RX_BYTE_W-1:0] r_shift;
            logic [INSTRUCTION_LENGTH-1:0]           w_cat;
            logic                                    w_last;

            // New byte enters at the top; earlier bytes drift toward bit 0.
            assign w_cat  = {byte_in, r_shift};
            assign w_last = (r_byte_idx == c_IDX_W'(c_BYTES - 1));

            assign word_out      = w_cat;
            assign word_complete = byte_valid && w_last;

            // Byte position counter and shift-in register; lowest byte drops out.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_byte_idx <= '0;
                    r_shift    <= '0;
                end else if (byte_valid) begin
                    r_byte_idx <= w_last ? '0 : r_byte_idx + 1'b1;
                    r_shift    <= w_cat[INSTRUCTION_LENGTH-1:RX_BYTE_W];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module : instr_mem_loader
//  Brief  : Accepts a length-prefixed byte stream, assembles little-endian
//           instructions and writes them into fetch-stage instruction memory
//           through the core debug write port, holding the core in reset
//           until the program has been loaded.
//  Rev    : 1.0  initial release
// ============================================================================
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int              XLEN               = 64,
    parameter int              INSTRUCTION_LENGTH = 32,
    parameter logic [XLEN-1:0] BASE_ADDR          = '0,
    parameter int              ADDR_STRIDE        = 4,
    parameter int              MAX_WORDS          = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          rx_valid,
    input  logic [RX_BYTE_W-1:0]          rx_data,
    output logic                          rx_ready,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          core_rst,
    output logic                          load_busy,
    output logic                          load_done,
    output logic                          load_error,
    output logic [LEN_W-1:0]              words_loaded
);

    loader_state_t                 r_state;
    logic                          r_rx_ready;
    logic                          r_dbg_wr_en;
    logic [XLEN-1:0]               r_dbg_addr;
    logic [XLEN-1:0]               r_next_addr;
    logic [INSTRUCTION_LENGTH-1:0] r_dbg_instr;
    logic                          r_core_rst;
    logic                          r_load_busy;
    logic                          r_load_done;
    logic                          r_load_error;
    logic [LEN_W-1:0]              r_count;
    logic [LEN_W-1:0]              r_words_loaded;

    logic                          w_rx_fire;
    logic                          w_start;
    logic [LEN_W-1:0]              w_len;
    logic                          w_len_bad;
    logic                          w_last_word;
    logic [INSTRUCTION_LENGTH-1:0] w_word;
    logic                          w_word_complete;

    assign w_rx_fire   = rx_valid && r_rx_ready;
    assign w_start     = load_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_len       = {rx_data, r_count[RX_BYTE_W-1:0]};
    assign w_len_bad   = (w_len == '0) || (w_len > LEN_W'(MAX_WORDS));
    // r_words_loaded doubles as the index of the word being written.
    assign w_last_word = ((r_words_loaded + LEN_W'(1)) == r_count);

    loader_word_assembler #(
        .INSTRUCTION_LENGTH (INSTRUCTION_LENGTH)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_start),
        .byte_valid    (w_rx_fire && (r_state == COLLECT)),
        .byte_in       (rx_data),
        .word_out      (w_word),
        .word_complete (w_word_complete)
    );

    // Load sequencer; every output is registered and set on the transition
    // into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rx_ready     <= 1'b0;
            r_dbg_wr_en    <= 1'b0;
            r_dbg_addr     <= BASE_ADDR;
            r_next_addr    <= BASE_ADDR;
            r_dbg_instr    <= '0;
            r_core_rst     <= 1'b1;
            r_load_busy    <= 1'b0;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_count        <= '0;
            r_words_loaded <= '0;
        end else begin
            r_dbg_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_state        <= LEN0;
                        r_rx_ready     <= 1'b1;
                        r_core_rst     <= 1'b1;
                        r_load_busy    <= 1'b1;
                        r_load_done    <= 1'b0;
                        r_load_error   <= 1'b0;
                        r_words_loaded <= '0;
                        r_next_addr    <= BASE_ADDR;
                    end
                end
                LEN0: begin
                    if (w_rx_fire) begin
                        r_count[RX_BYTE_W-1:0] <= rx_data;
                        r_state                <= LEN1;
                    end
                end
                LEN1: begin
                    if (w_rx_fire) begin
                        r_count <= w_len;
                        if (w_len_bad) begin
                            // Core stays in reset: nothing valid was loaded.
                            r_state      <= DONE;
                            r_rx_ready   <= 1'b0;
                            r_load_busy  <= 1'b0;
                            r_load_done  <= 1'b1;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (w_word_complete) begin
                        r_state     <= WRITE;
                        r_rx_ready  <= 1'b0;
                        r_dbg_wr_en <= 1'b1;
                        r_dbg_addr  <= r_next_addr;
                        r_dbg_instr <= w_word;
                        // Running sum wraps modulo 2^XLEN like the product form.
                        r_next_addr <= r_next_addr + XLEN'(ADDR_STRIDE);
                    end
                end
                WRITE: begin
                    r_words_loaded <= r_words_loaded + LEN_W'(1);
                    if (w_last_word) begin
                        r_state     <= DONE;
                        r_load_busy <= 1'b0;
                        r_load_done <= 1'b1;
                        r_core_rst  <= 1'b0;
                    end else begin
                        r_state    <= COLLECT;
                        r_rx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rx_ready  <= 1'b0;
                    r_load_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = r_rx_ready;
    assign dbg_wr_en    = r_dbg_wr_en;
    assign dbg_addr     = r_dbg_addr;
    assign dbg_instr    = r_dbg_instr;
    assign core_rst     = r_core_rst;
    assign load_busy    = r_load_busy;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire
